uart_rx_buffer: RTL and testbench
=================================

// Module: uart_rx_buffer
// PURPOSE
//  Receive-side buffer that sits directly downstream of the UART receive engine.
//  Captures each completed byte and its per-byte error flags (PERR, FERR) into a small FIFO.
//  Returns the handshake clear to the engine and presents a first-word-fall-through read port plus a status byte to the CPU/bus side.
// PARAMETERS
//  DEPTH  8  FIFO entries; must be a power of 2, minimum 2
//  AW     3  pointer width; AW = log2(DEPTH)
// PORTS
//  clk      in   1  system clock; single clock domain
//  rst      in   1  reset; synchronous, active-high
//  rx_data  in   8  byte from receive engine; valid while rx_rdy=1
//  rx_rdy   in   1  engine byte-ready level
//  rx_perr  in   1  engine parity error for the current byte
//  rx_ferr  in   1  engine framing error for the current byte
//  rx_ovf   in   1  engine overflow (a byte was lost before clr)
//  rx_clr   out  1  one-cycle clear pulse back to the engine
//  rd       in   1  CPU pop strobe; one pop per cycle while high
//  clr_ovf  in   1  clears the sticky overflow flag
//  dout     out  8  head-entry data; 8'h00 when empty
//  status   out  8  {3'b0, ovf, ferr_h, perr_h, full, ~empty}
//  level    out  AW+1  entry count (UART_RXBUF_LEVEL_EN only)
// BEHAVIOUR
//  Reset values: rx_clr=0, pointers=0, count=0, ovf=0, capture FSM in IDLE, dout=0, status=0.
//  Capture FSM:
//   - IDLE: rx_rdy=1 -> write attempt this cycle; go to ACK.
//   - ACK: rx_clr=1 for exactly one cycle; go to WAIT.
//   - WAIT: stay while rx_rdy=1; go to IDLE when rx_rdy=0. This guards against a level-held rx_rdy causing a double capture.
//  Write attempt: entry {rx_perr, rx_ferr, rx_data} is stored at wptr.
//   - wptr wraps modulo DEPTH.
//   - If full and no pop in the same cycle: entry is dropped and ovf is set. rx_clr is still issued.
//  Pop: rd=1 and ~empty -> rptr increments (mod DEPTH).
//   - rd while empty: ignored; no state change, no flag.
//  Simultaneous write and pop:
//   - Both occur and count is unchanged.
//   - When full, the pop frees the slot and the write is accepted.
//   - When empty, the write lands and the pop is ignored; count becomes 1.
//  count: AW+1 bits, range 0..DEPTH. full = (count==DEPTH), empty = (count==0).
//  dout, perr_h, ferr_h are taken combinationally from the head entry (FWFT).
//   - The new head is visible the cycle after the pop edge.
//   - Latency from the rx_rdy rise to the byte visible on dout is 1 clk.
//  ovf (sticky):
//   - Set by a dropped write or by rx_ovf=1 on any cycle.
//   - Cleared by clr_ovf. Set wins over clear in the same cycle.
//  rst mid-operation: FIFO contents are discarded and the FSM returns to IDLE.
//   - If the engine still holds rx_rdy=1, that byte is captured after reset releases.
// CONFIGURATION
//  UART_RXBUF_LEVEL_EN defined: level port exists and equals count.
//  UART_RXBUF_LEVEL_EN undefined: level port is absent. All other behaviour is identical.
// STRUCTURE
//  Shared package uart_pkg holds:
//   - RXBUF_ENTRY_W=10
//   - status bit indices (ST_RDY=0, ST_FULL=1, ST_PERR=2, ST_FERR=3, ST_OVF=4)
//   - capture FSM state encodings (IDLE/ACK/WAIT)
//  Sub-module uart_rxbuf_mem: DEPTH x 10 storage.
//   - Synchronous write.
//   - Asynchronous read by rptr.
//   - No reset on the array.
// TESTING
//  T1: rx_rdy held high 5 clks with rx_data=8'hA5, no errors.
//      -> exactly one rx_clr pulse; dout=A5, status=8'h01 one clk later.
//  T2: 8 bytes 8'h01..8'h08, then a 9th (8'h09).
//      -> status=8'h13 (rdy, full, ovf); 8 pops yield 01..08; 09 is absent.
//  T3: FIFO full, and the 9th capture coincides with rd=1.
//      -> no ovf; count stays 8; the last pop sequence ends with 09.
//  T4: byte 8'h3C with rx_perr=1, followed by 8'h3D clean.
//      -> status=8'h05 while 3C is head; after pop, status=8'h01 and dout=3D.
//  T5: rx_ovf pulse with clr_ovf=1 in the same cycle.
//      -> ovf=1; clr_ovf next cycle -> ovf=0.
//  T6: 3 entries buffered, rst asserted 1 clk, rd pulsed while empty.
//      -> status=0, dout=0, no pointer movement; level=0 with UART_RXBUF_LEVEL_EN.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive-buffer definitions: entry width, status bit positions
// and capture handshake state encodings.
package uart_pkg;

    localparam int RXBUF_ENTRY_W = 10;

    localparam int ST_RDY  = 0;
    localparam int ST_FULL = 1;
    localparam int ST_PERR = 2;
    localparam int ST_FERR = 3;
    localparam int ST_OVF  = 4;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_ACK  = 2'd1,
        CAP_WAIT = 2'd2
    } cap_state_e;

endpackage

// File: rtl/uart_rxbuf_mem.sv
// Receive buffer storage: DEPTH x RXBUF_ENTRY_W array, synchronous write,
// asynchronous read. The array carries no reset; occupancy is tracked outside.
module uart_rxbuf_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [AW-1:0]            waddr_i,
    input  logic [RXBUF_ENTRY_W-1:0] wdata_i,
    input  logic [AW-1:0]            raddr_i,
    output logic [RXBUF_ENTRY_W-1:0] rdata_o
);

    logic [RXBUF_ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: captures engine bytes with PERR/FERR into a FWFT FIFO
// and acknowledges the engine with rx_clr. Optional level port: UART_RXBUF_LEVEL_EN.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    input  logic        rx_perr,
    input  logic        rx_ferr,
    input  logic        rx_ovf,
    output logic        rx_clr,
    input  logic        rd,
    input  logic        clr_ovf,
    output logic [7:0]  dout,
`ifdef UART_RXBUF_LEVEL_EN
    output logic [7:0]  status,
    output logic [AW:0] level
`else
    output logic [7:0]  status
`endif
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    cap_state_e               state_q;
    logic                     rx_clr_q;
    logic [AW-1:0]            wptr_q, wptr_d;
    logic [AW-1:0]            rptr_q, rptr_d;
    logic [AW:0]              count_q, count_d;
    logic                     ovf_q, ovf_d;
    logic                     empty, full;
    logic                     wr_attempt, wr_ok, pop, drop;
    logic [RXBUF_ENTRY_W-1:0] head;
    logic                     perr_h, ferr_h;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

    // Only IDLE may capture, so a level-held rx_rdy yields a single write.
    assign wr_attempt = (state_q == CAP_IDLE) && rx_rdy;
    assign pop        = rd && !empty;
    assign wr_ok      = wr_attempt && (!full || pop);
    assign drop       = wr_attempt && full && !pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (wr_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_ok) begin
            count_d = count_q - 1'b1;
        end
        ovf_d = ovf_q;
        if (drop || rx_ovf) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CAP_IDLE;
            rx_clr_q <= 1'b0;
        end else begin
            rx_clr_q <= 1'b0;
            case (state_q)
                CAP_IDLE: begin
                    if (rx_rdy) begin
                        state_q  <= CAP_ACK;
                        rx_clr_q <= 1'b1;
                    end
                end
                CAP_ACK:  state_q <= CAP_WAIT;
                CAP_WAIT: begin
                    if (!rx_rdy) begin
                        state_q <= CAP_IDLE;
                    end
                end
                default:  state_q <= CAP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    uart_rxbuf_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_ok),
        .waddr_i (wptr_q),
        .wdata_i ({rx_perr, rx_ferr, rx_data}),
        .raddr_i (rptr_q),
        .rdata_o (head)
    );

    // Stale array contents are masked while the FIFO is empty.
    assign dout   = empty ? 8'h00 : head[7:0];
    assign perr_h = !empty && head[9];
    assign ferr_h = !empty && head[8];

    always_comb begin
        status          = 8'h00;
        status[ST_RDY]  = !empty;
        status[ST_FULL] = full;
        status[ST_PERR] = perr_h;
        status[ST_FERR] = ferr_h;
        status[ST_OVF]  = ovf_q;
    end

    assign rx_clr = rx_clr_q;

`ifdef UART_RXBUF_LEVEL_EN
    assign level = count_q;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: queue-based reference model updated
// after each clock edge, monitor comparing outputs on the falling edge.
module tb_uart_rx_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_rdy, rx_perr, rx_ferr, rx_ovf;
    logic        rx_clr;
    logic        rd, clr_ovf;
    logic [7:0]  dout;
    logic [7:0]  status;
`ifdef UART_RXBUF_LEVEL_EN
    logic [AW:0] level;
`endif

    int errors = 0;
    int checks = 0;

    logic [9:0] mdlQ[$];
    bit         mdlOvf = 1'b0;
    bit         captureNow = 1'b0;
    bit         monOn = 1'b0;
    int         clrSeen = 0;

    uart_rx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .rx_perr (rx_perr),
        .rx_ferr (rx_ferr),
        .rx_ovf  (rx_ovf),
        .rx_clr  (rx_clr),
        .rd      (rd),
        .clr_ovf (clr_ovf),
        .dout    (dout),
`ifdef UART_RXBUF_LEVEL_EN
        .status  (status),
        .level   (level)
`else
        .status  (status)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge, then apply the same edge to the reference model.
    task automatic tick();
        bit popOk;
        @(posedge clk);
        #2;
        if (rx_clr === 1'b1) clrSeen++;
        if (rst) begin
            mdlQ.delete();
            mdlOvf = 1'b0;
        end else begin
            bit dropped;
            dropped = 1'b0;
            popOk = rd && (mdlQ.size() > 0);
            if (popOk) void'(mdlQ.pop_front());
            if (captureNow) begin
                if (mdlQ.size() < DEPTH) mdlQ.push_back({rx_perr, rx_ferr, rx_data});
                else dropped = 1'b1;
            end
            mdlOvf = dropped || rx_ovf || (mdlOvf && !clr_ovf);
        end
        captureNow = 1'b0;
    endtask

    // One engine byte: rx_rdy held for 'hold' cycles, then low for two.
    task automatic applyStimulus(input logic [7:0] data, input bit perr, input bit ferr,
                                 input int hold, input bit rdCap, input bit randRd);
        rx_data    = data;
        rx_perr    = perr;
        rx_ferr    = ferr;
        rx_rdy     = 1'b1;
        captureNow = 1'b1;
        rd         = rdCap;
        clrSeen    = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            rd = randRd ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        rx_rdy  = 1'b0;
        rx_data = 8'($urandom);
        rx_perr = 1'($urandom);
        rx_ferr = 1'($urandom);
        tick();
        rd = randRd ? ($urandom_range(0, 3) == 0) : 1'b0;
        tick();
        rd = 1'b0;
        checkOutput("rx_clr pulse count", 32'(clrSeen), 32'd1);
    endtask

    task automatic popBytes(input int n);
        for (int i = 0; i < n; i++) begin
            rd = 1'b1;
            tick();
        end
        rd = 1'b0;
    endtask

    // Monitor: status/dout against the model; on a pop, the head leaving the FIFO.
    always @(negedge clk) begin
        if (monOn) begin
            logic [9:0] head;
            logic [7:0] expStatus;
            head = (mdlQ.size() != 0) ? mdlQ[0] : 10'h000;
            expStatus = {3'b000, mdlOvf, head[8], head[9],
                         (mdlQ.size() == DEPTH), (mdlQ.size() != 0)};
            checkOutput("status", 32'(status), 32'(expStatus));
            if (rd && mdlQ.size() != 0) checkOutput("popped byte", 32'(dout), 32'(head[7:0]));
            else checkOutput("dout", 32'(dout), 32'(head[7:0]));
`ifdef UART_RXBUF_LEVEL_EN
            checkOutput("level", 32'(level), 32'(mdlQ.size()));
`endif
        end
    end

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0; rx_perr = 1'b0; rx_ferr = 1'b0;
        rx_ovf = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        monOn = 1'b1;
        checkOutput("reset status", 32'(status), 32'h00);
        checkOutput("reset dout", 32'(dout), 32'h00);

        // T1: held rx_rdy captures once
        applyStimulus(8'hA5, 1'b0, 1'b0, 5, 1'b0, 1'b0);
        checkOutput("T1 dout", 32'(dout), 32'hA5);
        checkOutput("T1 status", 32'(status), 32'h01);
        popBytes(1);

        // T2: overfill drops the ninth byte
        for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 1'b0, 1'b0, 1 + (i % 3), 1'b0, 1'b0);
        checkOutput("T2 status", 32'(status), 32'h13);
        popBytes(8);
        checkOutput("T2 drained status", 32'(status), 32'h10);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // T3: ninth capture coincides with a pop
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1'b0, 1'b0, 2, 1'b0, 1'b0);
        applyStimulus(8'h09, 1'b0, 1'b0, 2, 1'b1, 1'b0);
        checkOutput("T3 status", 32'(status), 32'h03);
        popBytes(8);

        // T4: parity-error flag follows its byte
        applyStimulus(8'h3C, 1'b1, 1'b0, 1, 1'b0, 1'b0);
        applyStimulus(8'h3D, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        checkOutput("T4 status perr head", 32'(status), 32'h05);
        popBytes(1);
        checkOutput("T4 status clean head", 32'(status), 32'h01);
        checkOutput("T4 dout", 32'(dout), 32'h3D);
        popBytes(1);

        // T5: set wins over clear
        rx_ovf = 1'b1; clr_ovf = 1'b1;
        tick();
        rx_ovf = 1'b0;
        checkOutput("T5 ovf set", 32'(status), 32'h10);
        tick();
        clr_ovf = 1'b0;
        checkOutput("T5 ovf cleared", 32'(status), 32'h00);

        // T6: reset discards contents; pop while empty is ignored
        for (int i = 0; i < 3; i++) applyStimulus(8'hC0 + 8'(i), 1'b0, 1'($urandom), 1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("T6 status", 32'(status), 32'h00);
        checkOutput("T6 dout", 32'(dout), 32'h00);
        popBytes(1);
        checkOutput("T6 status after empty pop", 32'(status), 32'h00);
        applyStimulus(8'h5A, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        checkOutput("T6 pointer unmoved", 32'(dout), 32'h5A);
        popBytes(1);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            int op;
            op = $urandom_range(0, 19);
            if (op < 11) begin
                applyStimulus(8'($urandom), 1'($urandom), 1'($urandom),
                              $urandom_range(1, 4), 1'($urandom), 1'b1);
            end else if (op < 16) begin
                popBytes($urandom_range(1, 4));
            end else if (op < 18) begin
                rx_ovf  = ($urandom_range(0, 1) == 0);
                clr_ovf = ($urandom_range(0, 1) == 0);
                tick();
                rx_ovf  = 1'b0;
                clr_ovf = 1'b0;
            end else if (op == 18) begin
                clr_ovf = 1'b1;
                tick();
                clr_ovf = 1'b0;
            end else begin
                rst = ($urandom_range(0, 3) == 0);
                tick();
                rst = 1'b0;
            end
        end
        popBytes(DEPTH);
        monOn = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
